memory_arbiter: RTL and testbench

- Sits directly downstream of the cache block. Accepts its instruction-port request (iREN/iaddr) and data-port request (dREN/dWEN/daddr/dstore), and serialises them onto a single-ported RAM.
- Returns iwait/dwait and iload/dload to the cache block.
- Data requests have priority over instruction requests.
- A starvation counter guarantees instruction fetch progress.
- A watchdog terminates hung RAM accesses.

---
 rtl/memory_arbiter.sv | 129 ++++++++++++
 tb/tb_memory_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Serialises cache instruction/data requests onto one single-ported RAM, data first.
// Latency: grant one cycle after request; wait drops combinationally in the RAM-ready cycle.
// Backpressure: requester holds its request while wait=1; a watchdog bounds each access.
module memory_arbiter #(
    parameter int          STARVE_MAX = 4,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t      state;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wd_cnt;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic [31:0] iload_q;
    logic [31:0] dload_q;
    logic        wr_q;

    logic        d_req;
    logic        live;
    logic        wd_expired;
    logic        done;
    logic        i_done;
    logic        d_done;
    logic [31:0] rd_word;

    // Access is live only while its requester still asserts; dropping the request aborts it.
    always_comb begin
        d_req      = dREN | dWEN;
        live       = ((state == DGRANT) && d_req) || ((state == IGRANT) && iREN);
        wd_expired = (wd_cnt == WW'(TIMEOUT - 1));
        done       = live && (ram_ready || wd_expired);
        i_done     = done && (state == IGRANT);
        d_done     = done && (state == DGRANT);
        rd_word    = ram_ready ? ramload : ERR_WORD;
    end

    assign ramREN   = live && ((state == IGRANT) || !wr_q);
    assign ramWEN   = live && (state == DGRANT) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iwait    = !i_done;
    assign dwait    = !d_done;
    assign iload    = i_done ? rd_word : iload_q;
    assign dload    = (d_done && !wr_q) ? rd_word : dload_q;

    // Arbitration, request capture, starvation/watchdog counters and load holding registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            addr_q      <= '0;
            store_q     <= '0;
            iload_q     <= '0;
            dload_q     <= '0;
            wr_q        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (iREN && (starve_cnt == SW'(STARVE_MAX))) begin
                        state      <= IGRANT;
                        addr_q     <= iaddr;
                        wr_q       <= 1'b0;
                        starve_cnt <= '0;
                    end else if (d_req) begin
                        state   <= DGRANT;
                        addr_q  <= daddr;
                        store_q <= dstore;
                        wr_q    <= dWEN;
                        if (!iREN)
                            starve_cnt <= '0;
                        else if (starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                    end else if (iREN) begin
                        state      <= IGRANT;
                        addr_q     <= iaddr;
                        wr_q       <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                DGRANT, IGRANT: begin
                    if (done) begin
                        state <= IDLE;
                        if (state == IGRANT)
                            iload_q <= rd_word;
                        else if (!wr_q)
                            dload_q <= rd_word;
                        if (!ram_ready)
                            timeout_err <= 1'b1;
                    end else if (!live) begin
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, corner sequences, random vs model.
// Latency: outputs sampled 1ns after the falling edge, inputs driven on the falling edge.
// Backpressure: requesters in the random phase hold or drop requests freely; model tracks aborts.
module tb_memory_arbiter;

    localparam int          STARVE_MAX = 4;
    localparam int          TIMEOUT    = 16;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, timeout_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;

    memory_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iren;
        logic [31:0] ia;
        logic        dren;
        logic        dwen;
        logic [31:0] da;
        logic [31:0] ds;
        logic        rdy;
        logic [31:0] rl;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t tbl[13];

    // behavioural reference: who owns the RAM, what was captured, how long it has waited
    int          m_owner;    // 0 nobody, 1 data, 2 instruction
    logic [31:0] m_addr, m_store, m_iload, m_dload;
    logic        m_write, m_terr;
    int          m_starve, m_elapsed;

    task automatic drive_idle();
        iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
        ram_ready = 0; ramload = 0;
    endtask

    initial begin
        int n;
        int dcount;
        logic got_i;
        int rdy_pct;
        string s;

        tbl[0]  = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1, 32'h40, 1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h0,   32'h0,        32'h0,        32'h0};
        tbl[2]  = '{1, 32'h40, 1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 1, 1, 0, 32'h100, 32'h0,        32'h0,        32'h0};
        tbl[3]  = '{1, 32'h40, 1, 0, 32'h100, 32'h0,        0, 32'h0,        1, 1, 1, 0, 32'h100, 32'h0,        32'h0,        32'h0};
        tbl[4]  = '{1, 32'h40, 1, 0, 32'h100, 32'h0,        1, 32'hDEADBEEF, 1, 0, 1, 0, 32'h100, 32'h0,        32'h0,        32'hDEADBEEF};
        tbl[5]  = '{1, 32'h40, 0, 0, 32'h100, 32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h100, 32'h0,        32'h0,        32'hDEADBEEF};
        tbl[6]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 1, 1, 0, 32'h40,  32'h0,        32'h0,        32'hDEADBEEF};
        tbl[7]  = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        1, 32'hCAFEF00D, 0, 1, 1, 0, 32'h40,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
        tbl[8]  = '{0, 32'h40, 0, 0, 32'h0,   32'h0,        0, 32'h0,        1, 1, 0, 0, 32'h40,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
        tbl[9]  = '{0, 32'h0,  0, 1, 32'h200, 32'h12345678, 0, 32'h0,        1, 1, 0, 0, 32'h40,  32'h0,        32'hCAFEF00D, 32'hDEADBEEF};
        tbl[10] = '{0, 32'h0,  0, 1, 32'h999, 32'h11111111, 0, 32'h0,        1, 1, 0, 1, 32'h200, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
        tbl[11] = '{0, 32'h0,  0, 1, 32'h999, 32'h11111111, 1, 32'h55555555, 1, 0, 0, 1, 32'h200, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};
        tbl[12] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        1, 32'h1,        1, 1, 0, 0, 32'h200, 32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF};

        // reset state
        RST = 1;
        drive_idle();
        #1;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_dload", dload, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;

        // directed vector table: priority, one idle gap, write capture, idle ram_ready ignored
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            iREN = tbl[i].iren; iaddr = tbl[i].ia; dREN = tbl[i].dren; dWEN = tbl[i].dwen;
            daddr = tbl[i].da; dstore = tbl[i].ds; ram_ready = tbl[i].rdy; ramload = tbl[i].rl;
            #1;
            s = $sformatf("vec%0d", i);
            chk({s, "_iwait"},    32'(iwait),  32'(tbl[i].e_iwait));
            chk({s, "_dwait"},    32'(dwait),  32'(tbl[i].e_dwait));
            chk({s, "_ramREN"},   32'(ramREN), 32'(tbl[i].e_ren));
            chk({s, "_ramWEN"},   32'(ramWEN), 32'(tbl[i].e_wen));
            chk({s, "_ramaddr"},  ramaddr,     tbl[i].e_addr);
            chk({s, "_ramstore"}, ramstore,    tbl[i].e_store);
            chk({s, "_iload"},    iload,       tbl[i].e_iload);
            chk({s, "_dload"},    dload,       tbl[i].e_dload);
        end

        // starvation: continuous data traffic with iREN held; two rounds show the counter restarts
        @(negedge CLK);
        iREN = 1; iaddr = 32'h80; dREN = 1; dWEN = 0; daddr = 32'h300; ram_ready = 1; ramload = 32'h77;
        for (int round = 0; round < 2; round++) begin
            dcount = 0;
            got_i  = 0;
            for (int c = 0; c < 40 && !got_i; c++) begin
                #1;
                if (!dwait) dcount++;
                if (!iwait) got_i = 1;
                @(negedge CLK);
            end
            chk($sformatf("starve_round%0d_dgrants", round), dcount, 32'd4);
            chk($sformatf("starve_round%0d_igrant", round), 32'(got_i), 32'd1);
        end
        drive_idle();

        // abort: instruction request dropped mid-grant
        @(negedge CLK);
        iREN = 1; iaddr = 32'h44;
        @(negedge CLK);
        #1;
        chk("abort_grant_ramREN", 32'(ramREN), 32'd1);
        chk("abort_grant_ramaddr", ramaddr, 32'h44);
        @(negedge CLK);
        iREN = 0;
        #1;
        chk("abort_ramREN_drop", 32'(ramREN), 32'd0);
        chk("abort_iwait", 32'(iwait), 32'd1);
        @(negedge CLK);
        dREN = 1; daddr = 32'h500;
        #1;
        chk("abort_idle_ramREN", 32'(ramREN), 32'd0);
        chk("abort_idle_iwait", 32'(iwait), 32'd1);

        // watchdog: the data read granted next is never answered
        @(negedge CLK);
        #1;
        chk("wd_grant_ramaddr", ramaddr, 32'h500);
        chk("wd_grant_ramREN", 32'(ramREN), 32'd1);
        n = 1;
        while (dwait && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk("wd_grant_cycles", n, TIMEOUT);
        chk("wd_dload", dload, ERR_WORD);
        @(negedge CLK);
        dREN = 0;
        #1;
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        chk("wd_after_dload", dload, ERR_WORD);
        repeat (3) @(negedge CLK);
        #1;
        chk("wd_err_sticky", 32'(timeout_err), 32'd1);

        // asynchronous reset in the middle of a data grant
        @(negedge CLK);
        dREN = 1; daddr = 32'h600; dstore = 32'hABCD;
        @(negedge CLK);
        #1;
        chk("arst_pre_ramREN", 32'(ramREN), 32'd1);
        #2;
        RST = 1;
        #1;
        chk("arst_ramREN", 32'(ramREN), 32'd0);
        chk("arst_ramaddr", ramaddr, 32'h0);
        chk("arst_ramstore", ramstore, 32'h0);
        chk("arst_dwait", 32'(dwait), 32'd1);
        chk("arst_dload", dload, 32'h0);
        chk("arst_iload", iload, 32'h0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        drive_idle();
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;

        // random traffic against the reference model
        m_owner = 0; m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
        m_write = 0; m_terr = 0; m_starve = 0; m_elapsed = 0;
        rdy_pct = 60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic live, done, tmo, e_ren, e_wen, e_iw, e_dw;
            logic [31:0] word, e_il, e_dl;
            if (cyc % 500 == 0) rdy_pct = (cyc % 1500 == 0) ? 60 : ((cyc % 1500 == 500) ? 20 : 2);
            @(negedge CLK);
            if ($urandom_range(0, 3) == 0) iREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dREN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) dWEN = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) iaddr = $urandom;
            if ($urandom_range(0, 2) == 0) daddr = $urandom;
            if ($urandom_range(0, 2) == 0) dstore = $urandom;
            ramload   = $urandom;
            ram_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            live  = (m_owner == 1 && (dREN || dWEN)) || (m_owner == 2 && iREN);
            done  = live && (ram_ready || m_elapsed == TIMEOUT - 1);
            tmo   = done && !ram_ready;
            word  = tmo ? ERR_WORD : ramload;
            e_ren = live && (m_owner == 2 || !m_write);
            e_wen = live && m_owner == 1 && m_write;
            e_iw  = !(done && m_owner == 2);
            e_dw  = !(done && m_owner == 1);
            e_il  = (done && m_owner == 2) ? word : m_iload;
            e_dl  = (done && m_owner == 1 && !m_write) ? word : m_dload;
            checks++;
            if (iwait !== e_iw || dwait !== e_dw || ramREN !== e_ren || ramWEN !== e_wen ||
                ramaddr !== m_addr || ramstore !== m_store || iload !== e_il || dload !== e_dl ||
                timeout_err !== m_terr) begin
                errors++;
                $display("FAIL rand_cycle%0d: got iw=%b dw=%b ren=%b wen=%b a=%h s=%h il=%h dl=%h te=%b required iw=%b dw=%b ren=%b wen=%b a=%h s=%h il=%h dl=%h te=%b",
                         cyc, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, timeout_err,
                         e_iw, e_dw, e_ren, e_wen, m_addr, m_store, e_il, e_dl, m_terr);
            end
            @(posedge CLK);
            if (m_owner != 0) begin
                if (done) begin
                    if (m_owner == 2) m_iload = word;
                    else if (!m_write) m_dload = word;
                    if (tmo) m_terr = 1;
                    m_owner = 0;
                end else if (!live) begin
                    m_owner = 0;
                end else begin
                    m_elapsed++;
                end
            end else begin
                if (iREN && m_starve == STARVE_MAX) begin
                    m_owner = 2; m_addr = iaddr; m_write = 0; m_starve = 0; m_elapsed = 0;
                end else if (dREN || dWEN) begin
                    m_owner = 1; m_addr = daddr; m_store = dstore; m_write = dWEN; m_elapsed = 0;
                    m_starve = iREN ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                end else if (iREN) begin
                    m_owner = 2; m_addr = iaddr; m_write = 0; m_starve = 0; m_elapsed = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
